// File: rtl/gcn_phase_scheduler.sv
// Purpose : GCN layer sequencer - Transformation, then COO edge fetch, then one edge beat per cycle to aggregation.
// Latency : start->done = 1 + T_trans + 3 + beats cycles (beats = COO_NUM_OF_COLS, or more when symmetric edges are enabled).
// Backpr. : none; the aggregation datapath must accept one beat per AGGR cycle, and start is only sampled in IDLE/DONE.
//
// Ports:
//   clk, reset                       clock (rising edge), asynchronous active-low reset
//   start                            level run request
//   trans_start / trans_done         handshake with the Transformation engine
//   trans_read_address/enable_read   Transformation's memory request, passed through in IDLE/TRANS
//   mem_read_address/enable_read     shared memory read port (sync read, data one cycle later)
//   mem_data_in                      flat MEM_WORDS x DATA_WIDTH read data, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   fm_wm_read_row                   row select into FM_WM memory (follows aggr_src)
//   aggr_valid/src/dst               edge beat to the aggregation datapath
//   busy, done, err                  status; err is sticky for out-of-range node indices
//
// Optional build macro GCN_SYMMETRIC_EDGE_EN: each in-range non-self-loop edge is also
// emitted reversed (dst->src) on the following beat, making the graph undirected.
module gcn_phase_scheduler #(
   parameter int ADDRESS_WIDTH   = 13,
   parameter int MEM_WORDS       = 96,
   parameter int DATA_WIDTH      = 5,
   parameter int NUM_OF_NODES    = 6,
   parameter int COO_NUM_OF_COLS = 6,
   parameter int COO_BW          = $clog2(COO_NUM_OF_COLS),
   parameter logic [ADDRESS_WIDTH-1:0] COO_BASE_ADDR = 'h0400
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   output logic                            trans_start,
   input  logic                            trans_done,
   input  logic [ADDRESS_WIDTH-1:0]        trans_read_address,
   input  logic                            trans_enable_read,
   output logic [ADDRESS_WIDTH-1:0]        mem_read_address,
   output logic                            mem_enable_read,
   input  logic [MEM_WORDS*DATA_WIDTH-1:0] mem_data_in,
   output logic [COO_BW-1:0]               fm_wm_read_row,
   output logic                            aggr_valid,
   output logic [COO_BW-1:0]               aggr_src,
   output logic [COO_BW-1:0]               aggr_dst,
   output logic                            busy,
   output logic                            done,
   output logic                            err
);

   typedef enum logic [2:0] {
      S_IDLE, S_TRANS, S_COO_RD0, S_COO_RD1, S_COO_LAT, S_AGGR, S_DONE
   } state_t;

   localparam logic [COO_BW:0]   NODE_LIMIT = (COO_BW+1)'(NUM_OF_NODES);
   localparam logic [COO_BW-1:0] LAST_EDGE  = COO_BW'(COO_NUM_OF_COLS - 1);

   state_t            state_q, state_d;
   logic [COO_BW-1:0] edge_idx_q;
   logic [COO_BW-1:0] src_q [COO_NUM_OF_COLS];
   logic [COO_BW-1:0] dst_q [COO_NUM_OF_COLS];
   logic              err_q;

   logic [COO_BW-1:0] cur_src, cur_dst, beat_src, beat_dst;
   logic              edge_ok, last_edge, edge_finish;

   assign cur_src   = src_q[edge_idx_q];
   assign cur_dst   = dst_q[edge_idx_q];
   // Widened compare so a node limit equal to 2**COO_BW still works.
   assign edge_ok   = ({1'b0, cur_src} < NODE_LIMIT) && ({1'b0, cur_dst} < NODE_LIMIT);
   assign last_edge = (edge_idx_q == LAST_EDGE);

`ifdef GCN_SYMMETRIC_EDGE_EN
   // phase_q marks the reversed (dst->src) beat of the current edge.
   logic phase_q;
   logic need_reverse;
   assign need_reverse = edge_ok && (cur_src != cur_dst) && !phase_q;
   assign edge_finish  = !need_reverse;
   assign beat_src     = phase_q ? cur_dst : cur_src;
   assign beat_dst     = phase_q ? cur_src : cur_dst;
`else
   assign edge_finish  = 1'b1;
   assign beat_src     = cur_src;
   assign beat_dst     = cur_dst;
`endif

   assign err = err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      trans_start      = 1'b0;
      mem_read_address = '0;
      mem_enable_read  = 1'b0;
      fm_wm_read_row   = '0;
      aggr_valid       = 1'b0;
      aggr_src         = '0;
      aggr_dst         = '0;
      busy             = 1'b0;
      done             = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            mem_read_address = trans_read_address;
            mem_enable_read  = trans_enable_read;
            if (start) state_d = S_TRANS;
         end
         S_TRANS: begin
            busy             = 1'b1;
            trans_start      = 1'b1;
            mem_read_address = trans_read_address;
            mem_enable_read  = trans_enable_read;
            if (trans_done) state_d = S_COO_RD0;
         end
         S_COO_RD0: begin
            busy             = 1'b1;
            mem_enable_read  = 1'b1;
            mem_read_address = COO_BASE_ADDR;
            state_d          = S_COO_RD1;
         end
         S_COO_RD1: begin
            busy             = 1'b1;
            mem_enable_read  = 1'b1;
            mem_read_address = COO_BASE_ADDR + ADDRESS_WIDTH'(1);
            state_d          = S_COO_LAT;
         end
         S_COO_LAT: begin
            busy    = 1'b1;
            state_d = S_AGGR;
         end
         S_AGGR: begin
            busy           = 1'b1;
            aggr_valid     = edge_ok;
            aggr_src       = beat_src;
            aggr_dst       = beat_dst;
            fm_wm_read_row = beat_src;
            if (edge_finish && last_edge) state_d = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (!start) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         edge_idx_q <= '0;
         err_q      <= 1'b0;
         for (int k = 0; k < COO_NUM_OF_COLS; k++) begin
            src_q[k] <= '0;
            dst_q[k] <= '0;
         end
`ifdef GCN_SYMMETRIC_EDGE_EN
         phase_q    <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  err_q      <= 1'b0;
                  edge_idx_q <= '0;
`ifdef GCN_SYMMETRIC_EDGE_EN
                  phase_q    <= 1'b0;
`endif
               end
            end
            // Row0 (sources) read in RD0 arrives here.
            S_COO_RD1: begin
               for (int k = 0; k < COO_NUM_OF_COLS; k++)
                  src_q[k] <= mem_data_in[k*DATA_WIDTH +: COO_BW];
            end
            // Row1 (destinations) read in RD1 arrives here.
            S_COO_LAT: begin
               edge_idx_q <= '0;
               for (int k = 0; k < COO_NUM_OF_COLS; k++)
                  dst_q[k] <= mem_data_in[k*DATA_WIDTH +: COO_BW];
            end
            S_AGGR: begin
               if (!edge_ok) err_q <= 1'b1;
`ifdef GCN_SYMMETRIC_EDGE_EN
               phase_q <= need_reverse;
`endif
               // Hold on the last edge so the index never leaves the table.
               if (edge_finish && !last_edge) edge_idx_q <= edge_idx_q + COO_BW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gcn_phase_scheduler.sv
module tb_gcn_phase_scheduler;

   localparam int AW = 13;
   localparam int MW = 96;
   localparam int DW = 5;
   localparam int BW = 3;
   localparam int NE = 6;

   logic                clk = 1'b0;
   logic                reset;
   logic                start;
   logic                trans_start;
   logic                trans_done;
   logic [AW-1:0]       trans_read_address;
   logic                trans_enable_read;
   logic [AW-1:0]       mem_read_address;
   logic                mem_enable_read;
   logic [MW*DW-1:0]    mem_data_in;
   logic [BW-1:0]       fm_wm_read_row;
   logic                aggr_valid;
   logic [BW-1:0]       aggr_src;
   logic [BW-1:0]       aggr_dst;
   logic                busy;
   logic                done;
   logic                err;

   int vectors    = 0;
   int miscompares = 0;

   int src_img [NE];
   int dst_img [NE];

   // Per-cycle log of DUT outputs for the current run (index = cycles since start).
   logic          lg_ts   [256];
   logic          lg_en   [256];
   logic [AW-1:0] lg_addr [256];
   logic          lg_vld  [256];
   logic [BW-1:0] lg_src  [256];
   logic [BW-1:0] lg_dst  [256];
   logic [BW-1:0] lg_row  [256];
   logic          lg_err  [256];
   int            done_cyc;

   gcn_phase_scheduler dut (
      .clk(clk), .reset(reset), .start(start),
      .trans_start(trans_start), .trans_done(trans_done),
      .trans_read_address(trans_read_address), .trans_enable_read(trans_enable_read),
      .mem_read_address(mem_read_address), .mem_enable_read(mem_enable_read),
      .mem_data_in(mem_data_in), .fm_wm_read_row(fm_wm_read_row),
      .aggr_valid(aggr_valid), .aggr_src(aggr_src), .aggr_dst(aggr_dst),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory holding the COO rows.
   logic [MW*DW-1:0] mem_nxt;
   always @(posedge clk) begin
      if (mem_enable_read) begin
         mem_nxt = '0;
         for (int k = 0; k < NE; k++) begin
            if (mem_read_address == 13'h400) mem_nxt[k*DW +: DW] = DW'(src_img[k]);
            if (mem_read_address == 13'h401) mem_nxt[k*DW +: DW] = DW'(dst_img[k]);
         end
         mem_data_in <= mem_nxt;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise start and run until done (or abort_cyc); Transformation lasts t_trans cycles.
   task automatic run_layer(input int t_trans, input int abort_cyc);
      int tcount;
      int cyc;
      tcount = 0;
      cyc = 0;
      done_cyc = -1;
      trans_read_address = 13'h201;
      trans_enable_read  = 1'b1;
      trans_done = 1'b0;
      start = 1'b1;
      while (cyc < 200 && done_cyc < 0 && cyc != abort_cyc) begin
         tick();
         cyc++;
         if (trans_start) begin
            tcount++;
            trans_done = (tcount == t_trans);
         end else begin
            trans_done = 1'b0;
         end
         lg_ts[cyc] = trans_start;   lg_en[cyc] = mem_enable_read;
         lg_addr[cyc] = mem_read_address;
         lg_vld[cyc] = aggr_valid;   lg_src[cyc] = aggr_src;
         lg_dst[cyc] = aggr_dst;     lg_row[cyc] = fm_wm_read_row;
         lg_err[cyc] = err;
         if (done) done_cyc = cyc;
      end
      if (abort_cyc < 0) begin
         vectors++;
         if (done_cyc < 0) begin
            miscompares++;
            $display("FAIL run_timeout: done never rose within 200 cycles");
         end
      end
   endtask

   // Beats for the ring graph, starting at cycle c0 (optionally one invalid beat).
   task automatic check_beats(input string name, input int c0, input int bad_beat);
      for (int k = 0; k < NE; k++) begin
         vectors++;
         if (k == bad_beat) begin
            if (lg_vld[c0+k] !== 1'b0) begin
               miscompares++;
               $display("FAIL %s beat%0d valid: got %b want 0", name, k, lg_vld[c0+k]);
            end
         end else if ({lg_vld[c0+k], lg_src[c0+k], lg_dst[c0+k], lg_row[c0+k]} !==
                      {1'b1, BW'(src_img[k]), BW'(dst_img[k]), BW'(src_img[k])}) begin
            miscompares++;
            $display("FAIL %s beat%0d: got v=%b src=%0d dst=%0d row=%0d want v=1 src=%0d dst=%0d row=%0d",
                     name, k, lg_vld[c0+k], lg_src[c0+k], lg_dst[c0+k], lg_row[c0+k],
                     src_img[k], dst_img[k], src_img[k]);
         end
      end
   endtask

   task automatic check_zero(input string name);
      vectors++;
      if ({trans_start, mem_enable_read, mem_read_address, fm_wm_read_row, aggr_valid,
           aggr_src, aggr_dst, busy, done, err} !== '0) begin
         miscompares++;
         $display("FAIL %s outputs: ts=%b en=%b addr=%h row=%0d v=%b src=%0d dst=%0d busy=%b done=%b err=%b want all 0",
                  name, trans_start, mem_enable_read, mem_read_address, fm_wm_read_row,
                  aggr_valid, aggr_src, aggr_dst, busy, done, err);
      end
   endtask

   task automatic test_reset();
      start = 1'b0; trans_done = 1'b0;
      trans_read_address = '0; trans_enable_read = 1'b0;
      reset = 1'b0;
      #3;
      check_zero("reset_async");
      tick(); tick();
      reset = 1'b1;
      tick();
      check_zero("reset_idle");
   endtask

   task automatic test_basic();
      for (int k = 0; k < NE; k++) begin
         src_img[k] = k;
         dst_img[k] = (k + 1) % NE;
      end
      run_layer(20, -1);
      vectors++;
      if (done_cyc !== 30) begin
         miscompares++;
         $display("FAIL basic_latency: done at cycle %0d want 30", done_cyc);
      end
      vectors++;
      if (lg_ts[1] !== 1'b1 || lg_ts[20] !== 1'b1 || lg_ts[21] !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_trans_start: c1=%b c20=%b c21=%b want 1 1 0", lg_ts[1], lg_ts[20], lg_ts[21]);
      end
      vectors++;
      if ({lg_en[5], lg_addr[5]} !== {1'b1, 13'h201}) begin
         miscompares++;
         $display("FAIL trans_mux: en=%b addr=%h want 1 0201", lg_en[5], lg_addr[5]);
      end
      vectors++;
      if ({lg_en[21], lg_addr[21]} !== {1'b1, 13'h400}) begin
         miscompares++;
         $display("FAIL coo_rd0: en=%b addr=%h want 1 0400", lg_en[21], lg_addr[21]);
      end
      vectors++;
      if ({lg_en[22], lg_addr[22]} !== {1'b1, 13'h401}) begin
         miscompares++;
         $display("FAIL coo_rd1: en=%b addr=%h want 1 0401", lg_en[22], lg_addr[22]);
      end
      vectors++;
      if (lg_en[23] !== 1'b0) begin
         miscompares++;
         $display("FAIL coo_lat_en: got %b want 0", lg_en[23]);
      end
      check_beats("basic", 24, -1);
      vectors++;
      if ({busy, aggr_valid, err} !== 3'b000) begin
         miscompares++;
         $display("FAIL basic_done_status: busy=%b valid=%b err=%b want 0 0 0", busy, aggr_valid, err);
      end
   endtask

   task automatic test_done_hold();
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if ({done, trans_start, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL done_hold%0d: done=%b ts=%b busy=%b want 1 0 0", i, done, trans_start, busy);
         end
      end
      start = 1'b0;
      tick();
      vectors++;
      if ({done, trans_start, busy} !== 3'b000) begin
         miscompares++;
         $display("FAIL done_release: done=%b ts=%b busy=%b want 0 0 0", done, trans_start, busy);
      end
   endtask

   task automatic test_err();
      src_img[2] = 6;
      run_layer(2, -1);
      vectors++;
      if (done_cyc !== 12) begin
         miscompares++;
         $display("FAIL err_latency: done at cycle %0d want 12", done_cyc);
      end
      check_beats("err", 6, 2);
      vectors++;
      if ({lg_err[8], lg_err[9], err} !== 3'b011) begin
         miscompares++;
         $display("FAIL err_sticky: c8=%b c9=%b done=%b want 0 1 1", lg_err[8], lg_err[9], err);
      end
      start = 1'b0;
      tick();
      vectors++;
      if ({err, done} !== 2'b10) begin
         miscompares++;
         $display("FAIL err_idle: err=%b done=%b want 1 0", err, done);
      end
   endtask

   task automatic test_reset_mid();
      src_img[2] = 2;
      run_layer(3, 10);
      vectors++;
      if (lg_err[1] !== 1'b0) begin
         miscompares++;
         $display("FAIL err_clear_on_start: got %b want 0", lg_err[1]);
      end
      vectors++;
      if ({lg_vld[10], lg_src[10], lg_dst[10]} !== {1'b1, 3'd3, 3'd4}) begin
         miscompares++;
         $display("FAIL mid_beat3: v=%b src=%0d dst=%0d want 1 3 4", lg_vld[10], lg_src[10], lg_dst[10]);
      end
      start = 1'b0; trans_done = 1'b0;
      trans_read_address = '0; trans_enable_read = 1'b0;
      #2 reset = 1'b0;
      #1;
      check_zero("reset_mid");
      tick();
      check_zero("reset_mid_hold");
      reset = 1'b1;
      tick();
      run_layer(3, -1);
      vectors++;
      if (done_cyc !== 13 || lg_ts[1] !== 1'b1) begin
         miscompares++;
         $display("FAIL restart: done at %0d ts1=%b want 13 1", done_cyc, lg_ts[1]);
      end
      check_beats("restart", 7, -1);
      start = 1'b0;
      tick();
   endtask

   initial begin
      mem_data_in = '0;
      for (int k = 0; k < NE; k++) begin
         src_img[k] = 0;
         dst_img[k] = 0;
      end
      test_reset();
      test_basic();
      test_done_hold();
      test_err();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
